// File: rtl/rmii_tx.sv
// ---------------------------------------------------------------------------
// rmii_tx
// Serialises an upstream byte stream into an RMII transmit frame. The block
// sends the preamble and SFD, then the payload, zero padding up to
// MIN_PAYLOAD, and the IEEE 802.3 CRC-32. It then holds an inter-frame gap.
// An underrun or oversize frame is closed with an inverted FCS so the far end
// drops it, and tx_err pulses for one cycle. After an oversize abort the rest
// of the upstream frame is drained and discarded.
//
// Ports
//   eth_clkin  in   50 MHz RMII reference clock (single clock domain)
//   eth_rstn   in   asynchronous active-low reset
//   tx_vld     in   upstream byte valid
//   tx_dat     in   upstream payload byte (destination MAC first)
//   tx_last    in   final payload byte, qualified by tx_vld
//   tx_rdy     out  byte taken on an edge where tx_vld and tx_rdy are high
//   tx_err     out  one-cycle pulse on underrun or oversize abort
//   eth_txen   out  RMII transmit enable
//   eth_txd    out  RMII transmit dibit, LSB dibit first, 4 clocks per byte
// ---------------------------------------------------------------------------
module rmii_tx #(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_PAYLOAD = 60,
    parameter int MAX_PAYLOAD = 1514
) (
    input  logic       eth_clkin,
    input  logic       eth_rstn,
    input  logic       tx_vld,
    input  logic [7:0] tx_dat,
    input  logic       tx_last,
    output logic       tx_rdy,
    output logic       tx_err,
    output logic       eth_txen,
    output logic [1:0] eth_txd
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, DATA, PAD, FCS, IFG, DRAIN
    } state_t;

    // What to do at the boundary between two wire bytes.
    typedef enum logic [2:0] {
        ACT_PRE, ACT_DATA, ACT_PAD, ACT_FCS, ACT_FCS_NEXT, ACT_END
    } act_t;

    localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES * 4 - 1);

    function automatic logic [31:0] crc32Byte(input logic [31:0] crc,
                                              input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    state_t      state_q;
    logic [1:0]  dib_q;
    logic [2:0]  idx_q;
    logic [10:0] cnt_q;
    logic [15:0] gap_q;
    logic [7:0]  cur_q;
    logic [23:0] fcs_q;
    logic [31:0] crc_q;
    logic        last_q;
    logic        oversize_q;
    logic        tx_rdy_q;
    logic        tx_err_q;
    logic        eth_txen_q;
    logic [1:0]  eth_txd_q;

    logic [31:0] crc_dat_d;
    logic [31:0] crc_pad_d;
    logic [31:0] fcs_val_d;
    logic [1:0]  dibit_d;
    logic [7:0]  pre_byte_d;
    logic        need_byte_d;
    logic        err_d;
    logic        ovs_d;
    act_t        act_d;

    // Byte-boundary decision and datapath helpers. act_d is only acted on
    // when the 4th dibit of the current byte is on the wire.
    always_comb begin
        crc_dat_d  = crc32Byte(crc_q, tx_dat);
        crc_pad_d  = crc32Byte(crc_q, 8'h00);
        pre_byte_d = (idx_q == 3'd6) ? 8'hD5 : 8'h55;
        case (dib_q)
            2'd0:    dibit_d = cur_q[3:2];
            2'd1:    dibit_d = cur_q[5:4];
            default: dibit_d = cur_q[7:6];
        endcase
        // A request goes out only where the following byte must come from
        // upstream: after the SFD and after each non-final payload byte
        // that does not already fill the frame.
        need_byte_d = ((state_q == PREAMBLE) && (idx_q == 3'd7)) ||
                      ((state_q == DATA) && !last_q && (cnt_q != MAX_CNT));

        act_d = ACT_END;
        err_d = 1'b0;
        ovs_d = 1'b0;
        case (state_q)
            PREAMBLE: begin
                if (idx_q != 3'd7) begin
                    act_d = ACT_PRE;
                end else if (tx_vld) begin
                    act_d = ACT_DATA;
                end else begin
                    act_d = ACT_FCS;
                    err_d = 1'b1;
                end
            end
            DATA: begin
                if (last_q) begin
                    act_d = (cnt_q < MIN_CNT) ? ACT_PAD : ACT_FCS;
                end else if (cnt_q == MAX_CNT) begin
                    act_d = ACT_FCS;
                    err_d = 1'b1;
                    ovs_d = 1'b1;
                end else if (tx_vld) begin
                    act_d = ACT_DATA;
                end else begin
                    act_d = ACT_FCS;
                    err_d = 1'b1;
                end
            end
            PAD:     act_d = (cnt_q < MIN_CNT) ? ACT_PAD : ACT_FCS;
            FCS:     act_d = (idx_q != 3'd3) ? ACT_FCS_NEXT : ACT_END;
            default: act_d = ACT_END;
        endcase

        // A good FCS is the complemented CRC; an aborted frame sends the
        // uncomplemented register, i.e. the bitwise inverse of the good FCS.
        fcs_val_d = err_d ? crc_q : ~crc_q;
    end

    // Main FSM. Every output is a register loaded one clock ahead of the
    // wire, so each boundary action writes the first dibit of the new byte.
    always_ff @(posedge eth_clkin or negedge eth_rstn) begin
        if (!eth_rstn) begin
            state_q    <= IDLE;
            dib_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            cur_q      <= '0;
            fcs_q      <= '0;
            crc_q      <= '0;
            last_q     <= 1'b0;
            oversize_q <= 1'b0;
            tx_rdy_q   <= 1'b0;
            tx_err_q   <= 1'b0;
            eth_txen_q <= 1'b0;
            eth_txd_q  <= 2'b00;
        end else begin
            tx_rdy_q <= 1'b0;
            tx_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_vld) begin
                        state_q    <= PREAMBLE;
                        eth_txen_q <= 1'b1;
                        eth_txd_q  <= 2'b01;
                        cur_q      <= 8'h55;
                        dib_q      <= 2'd0;
                        idx_q      <= 3'd0;
                        cnt_q      <= '0;
                        last_q     <= 1'b0;
                        oversize_q <= 1'b0;
                        crc_q      <= 32'hFFFF_FFFF;
                    end
                end
                IFG: begin
                    if (gap_q == IFG_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                DRAIN: begin
                    if (tx_vld && tx_rdy_q && tx_last) begin
                        state_q <= IFG;
                        gap_q   <= '0;
                    end else begin
                        tx_rdy_q <= 1'b1;
                    end
                end
                default: begin
                    if (dib_q != 2'd3) begin
                        dib_q     <= dib_q + 2'd1;
                        eth_txd_q <= dibit_d;
                        if (dib_q == 2'd2) begin
                            tx_rdy_q <= need_byte_d;
                        end
                    end else begin
                        dib_q <= 2'd0;
                        case (act_d)
                            ACT_PRE: begin
                                idx_q     <= idx_q + 3'd1;
                                cur_q     <= pre_byte_d;
                                eth_txd_q <= pre_byte_d[1:0];
                            end
                            ACT_DATA: begin
                                state_q   <= DATA;
                                cur_q     <= tx_dat;
                                eth_txd_q <= tx_dat[1:0];
                                last_q    <= tx_last;
                                cnt_q     <= cnt_q + 11'd1;
                                crc_q     <= crc_dat_d;
                            end
                            ACT_PAD: begin
                                state_q   <= PAD;
                                cur_q     <= 8'h00;
                                eth_txd_q <= 2'b00;
                                cnt_q     <= cnt_q + 11'd1;
                                crc_q     <= crc_pad_d;
                            end
                            ACT_FCS: begin
                                state_q    <= FCS;
                                idx_q      <= 3'd0;
                                cur_q      <= fcs_val_d[7:0];
                                eth_txd_q  <= fcs_val_d[1:0];
                                fcs_q      <= fcs_val_d[31:8];
                                tx_err_q   <= err_d;
                                oversize_q <= ovs_d;
                            end
                            ACT_FCS_NEXT: begin
                                idx_q     <= idx_q + 3'd1;
                                cur_q     <= fcs_q[7:0];
                                eth_txd_q <= fcs_q[1:0];
                                fcs_q     <= {8'h00, fcs_q[23:8]};
                            end
                            default: begin
                                eth_txen_q <= 1'b0;
                                eth_txd_q  <= 2'b00;
                                gap_q      <= '0;
                                if (oversize_q) begin
                                    state_q  <= DRAIN;
                                    tx_rdy_q <= 1'b1;
                                end else begin
                                    state_q <= IFG;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign tx_rdy   = tx_rdy_q;
    assign tx_err   = tx_err_q;
    assign eth_txen = eth_txen_q;
    assign eth_txd  = eth_txd_q;

endmodule

// File: tb/tb_rmii_tx.sv
// ---------------------------------------------------------------------------
// tb_rmii_tx
// Scoreboard bench for rmii_tx. The stimulus side computes each frame's
// expected wire image and pushes it into queues. A monitor rebuilds frames
// from eth_txen/eth_txd and compares them whenever a frame ends.
// ---------------------------------------------------------------------------
module tb_rmii_tx;

    localparam int MIN_PAY = 60;
    localparam int MAX_PAY = 1514;

    typedef struct {
        int          wireBytes;
        int          payBytes;
        logic [31:0] fcs;
        int          errs;
        int          gap;
        bit          aborted;
    } frame_t;

    logic       clk    = 1'b0;
    logic       rstN   = 1'b1;
    logic       txVld  = 1'b0;
    logic [7:0] txDat  = 8'h00;
    logic       txLast = 1'b0;
    logic       txRdy;
    logic       txErr;
    logic       ethTxen;
    logic [1:0] ethTxd;

    frame_t     expFrameQ[$];
    logic [7:0] expPayQ[$];
    logic [7:0] monBytes[$];

    int checks   = 0;
    int passes   = 0;
    int cyc      = 0;
    int strayErr = 0;

    rmii_tx #(
        .IFG_BYTES  (12),
        .MIN_PAYLOAD(MIN_PAY),
        .MAX_PAYLOAD(MAX_PAY)
    ) dut (
        .eth_clkin(clk),
        .eth_rstn (rstN),
        .tx_vld   (txVld),
        .tx_dat   (txDat),
        .tx_last  (txLast),
        .tx_rdy   (txRdy),
        .tx_err   (txErr),
        .eth_txen (ethTxen),
        .eth_txd  (ethTxd)
    );

    always #10 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Reference CRC-32, one bit at a time, LSB of each byte first.
    function automatic logic [31:0] crcRef(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = crc;
        for (int b = 0; b < 8; b++) begin
            fb = r[0] ^ d[b];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB8_8320;
        end
        return r;
    endfunction

    function automatic logic [7:0] patByte(input int i, input int seed);
        int v;
        v = (seed == 0) ? i : (i * seed + 90);
        return v[7:0];
    endfunction

    function automatic logic [7:0] monByte(input int i);
        if (i < monBytes.size()) return monBytes[i];
        return 8'h00;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name, input string why);
        checks++;
        $display("[TB] FAIL %s: %s", name, why);
    endtask

    task automatic finishRun();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    // Offer one byte and hold it until the DUT takes it.
    task automatic putByte(input logic [7:0] d, input bit last);
        int waited;
        waited = 0;
        txVld  = 1'b1;
        txDat  = d;
        txLast = last;
        @(negedge clk);
        while (!txRdy) begin
            waited++;
            if (waited > 400) begin
                failNow("handshakeTimeout", "tx_rdy never rose within 400 cycles");
                finishRun();
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    // Leave tx_vld low across one byte request so the DUT sees an underrun.
    task automatic dropRequest();
        int waited;
        waited = 0;
        txVld  = 1'b0;
        @(negedge clk);
        while (!txRdy) begin
            waited++;
            if (waited > 400) begin
                failNow("dropTimeout", "tx_rdy never rose within 400 cycles");
                finishRun();
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    // Queue the expected frame, then drive its payload.
    // dropAt > 0 withholds the byte at that request number.
    task automatic applyStimulus(input int n, input int seed, input int dropAt, input int gapExp);
        frame_t      f;
        logic [31:0] crc;
        logic [7:0]  b;
        int          sent;
        int          pay;
        bit          abort;
        abort = (dropAt > 0) || (n > MAX_PAY);
        sent  = (dropAt > 0) ? (dropAt - 1) : ((n > MAX_PAY) ? MAX_PAY : n);
        crc   = 32'hFFFF_FFFF;
        for (int i = 0; i < sent; i++) begin
            b   = patByte(i, seed);
            crc = crcRef(crc, b);
            expPayQ.push_back(b);
        end
        pay = sent;
        if (!abort) begin
            for (int i = sent; i < MIN_PAY; i++) begin
                crc = crcRef(crc, 8'h00);
                expPayQ.push_back(8'h00);
                pay++;
            end
        end
        f.wireBytes = 8 + pay + 4;
        f.payBytes  = pay;
        f.fcs       = abort ? crc : ~crc;
        f.errs      = abort ? 1 : 0;
        f.gap       = gapExp;
        f.aborted   = 1'b0;
        expFrameQ.push_back(f);

        for (int i = 0; i < n; i++) begin
            if ((dropAt > 0) && (i == dropAt - 1)) begin
                dropRequest();
                break;
            end
            putByte(patByte(i, seed), (i == n - 1));
        end
    endtask

    // Compare one completed wire frame against the head of the scoreboard.
    task automatic checkFrame(input int nDib, input int errCnt, input int gapSeen);
        frame_t      f;
        logic [63:0] pre;
        logic [31:0] fcs;
        logic [7:0]  b;
        int          bad;
        int          p;
        if (expFrameQ.size() == 0) begin
            failNow("unexpectedFrame", $sformatf("frame of %0d dibits with nothing queued", nDib));
            return;
        end
        f = expFrameQ.pop_front();
        if (f.aborted) begin
            $display("[TB] frame cut by reset after %0d dibits", nDib);
            return;
        end
        checkOutput("txenCycles", 64'(nDib), 64'(f.wireBytes * 4));
        pre = '0;
        for (int i = 0; i < 8; i++) pre[8*i +: 8] = monByte(i);
        checkOutput("preambleSfd", pre, 64'hD555_5555_5555_5555);
        bad = 0;
        for (int i = 0; i < f.payBytes; i++) begin
            b = expPayQ.pop_front();
            if (monByte(8 + i) !== b) bad++;
        end
        checkOutput("payloadBadBytes", 64'(bad), 64'd0);
        p   = 8 + f.payBytes;
        fcs = {monByte(p + 3), monByte(p + 2), monByte(p + 1), monByte(p)};
        checkOutput("fcs", {32'h0, fcs}, {32'h0, f.fcs});
        checkOutput("errPulses", 64'(errCnt), 64'(f.errs));
        if (f.gap >= 0) checkOutput("ifgGap", 64'(gapSeen), 64'(f.gap));
    endtask

    // Monitor: rebuild bytes from the dibit stream while eth_txen is high.
    initial begin
        bit         inFrame;
        int         nDib;
        int         errCnt;
        int         riseCyc;
        int         fallCyc;
        logic [7:0] sh;
        inFrame = 1'b0;
        nDib    = 0;
        errCnt  = 0;
        riseCyc = 0;
        fallCyc = -1000;
        sh      = 8'h00;
        forever begin
            @(negedge clk);
            if (ethTxen) begin
                if (!inFrame) begin
                    inFrame = 1'b1;
                    nDib    = 0;
                    errCnt  = 0;
                    riseCyc = cyc;
                    monBytes.delete();
                end
                sh = {ethTxd, sh[7:2]};
                nDib++;
                if (nDib % 4 == 0) monBytes.push_back(sh);
                if (txErr) errCnt++;
            end else begin
                if (txErr) strayErr++;
                if (inFrame) begin
                    inFrame = 1'b0;
                    checkFrame(nDib, errCnt, riseCyc - fallCyc);
                    fallCyc = cyc;
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        frame_t f;
        #1 rstN = 1'b0;
        #5;
        checkOutput("resetOutputs", {59'h0, txRdy, txErr, ethTxen, ethTxd}, 64'h0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        applyStimulus(60, 0, 0, -1);
        applyStimulus(14, 7, 0, -1);
        applyStimulus(30, 5, 21, -1);
        applyStimulus(64, 11, 0, -1);
        applyStimulus(61, 13, 0, 49);
        applyStimulus(1515, 1, 0, -1);

        f.wireBytes = 0;
        f.payBytes  = 0;
        f.fcs       = 32'h0;
        f.errs      = 0;
        f.gap       = -1;
        f.aborted   = 1'b1;
        expFrameQ.push_back(f);
        for (int i = 0; i < 6; i++) putByte(8'hA0 + 8'(i), 1'b0);
        @(posedge clk);
        #2;
        checkOutput("txenBeforeReset", {63'h0, ethTxen}, 64'h1);
        #1 rstN = 1'b0;
        #1;
        checkOutput("asyncResetOutputs", {59'h0, txRdy, txErr, ethTxen, ethTxd}, 64'h0);
        txVld = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        applyStimulus(20, 3, 0, -1);
        txVld  = 1'b0;
        txLast = 1'b0;

        for (int k = 0; (k < 2000) && (expFrameQ.size() != 0); k++) @(negedge clk);
        if (expFrameQ.size() != 0) begin
            failNow("framesOutstanding", $sformatf("%0d frames never seen", expFrameQ.size()));
        end
        checkOutput("leftoverPayload", 64'(expPayQ.size()), 64'd0);
        checkOutput("strayErrPulses", 64'(strayErr), 64'd0);
        finishRun();
    end

endmodule

// File: doc/rmii_tx.md
RMII_TX -- requirements
Module: rmii_tx

Interface
REQ-001 Parameter IFG_BYTES, default 12: minimum inter-frame gap in byte times (4 clocks each).
REQ-002 Parameter MIN_PAYLOAD, default 60: minimum bytes between SFD and FCS; shorter frames are padded.
REQ-003 Parameter MAX_PAYLOAD, default 1514: maximum bytes between SFD and FCS.
REQ-004 eth_clkin  input  1  50 MHz RMII reference clock; one clock serves the whole block.
REQ-005 eth_rstn  input  1  reset, asynchronous and active-low.
REQ-006 tx_vld  input  1  upstream byte valid.
REQ-007 tx_dat  input  8  upstream payload byte (destination MAC first, no preamble, no FCS).
REQ-008 tx_last  input  1  marks final payload byte; qualified by tx_vld.
REQ-009 tx_rdy  output  1  byte accepted on a rising edge where tx_vld and tx_rdy are both high.
REQ-010 tx_err  output  1  one-cycle pulse on underrun or oversize abort.
REQ-011 eth_txen  output  1  RMII transmit enable.
REQ-012 eth_txd  output  2  RMII transmit dibit; each byte is sent LSB dibit first, 4 clocks per byte.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have the states IDLE, PREAMBLE, DATA, PAD, FCS, IFG and DRAIN.
REQ-015 IDLE: eth_txen=0, eth_txd=00, tx_rdy=0; tx_vld=1 sampled -> PREAMBLE, with eth_txen rising on the next clock.
REQ-016 PREAMBLE SHALL send seven 0x55 bytes then 0xD5 (32 cycles; dibits 01 x31, then 11), without consuming input.
REQ-017 tx_rdy SHALL be high only in the single cycle where the next byte is needed: the 4th dibit cycle of the SFD, and the 4th dibit cycle of each DATA byte that was not tx_last.
REQ-018 DATA: the accepted byte SHALL be sent in the following 4 cycles, and each payload byte SHALL be counted (11-bit counter).
REQ-019 After tx_last, if count < MIN_PAYLOAD -> PAD, sending 0x00 bytes until count = MIN_PAYLOAD; else -> FCS.
REQ-020 FCS SHALL be the IEEE 802.3 CRC-32 (reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final complement) over payload and pad, sent low byte first; the existing crc32 block, byte-wide, may be reused.
REQ-021 Underrun: tx_vld=0 in a tx_rdy cycle in DATA -> pulse tx_err, go to FCS and send the bitwise-inverted correct FCS; eth_txen SHALL never drop mid-byte.
REQ-022 Oversize: count reaches MAX_PAYLOAD without tx_last -> send inverted FCS, pulse tx_err, then enter DRAIN.
REQ-023 DRAIN SHALL hold tx_rdy=1 with eth_txen=0, discarding bytes until tx_last is accepted, then go to IFG.
REQ-024 After the 4th FCS byte, eth_txen and eth_txd SHALL fall to 0 together -> IFG.
REQ-025 IFG SHALL hold eth_txen=0 for IFG_BYTES*4 cycles -> IDLE; tx_vld is ignored during IFG.
REQ-026 The frame length on the wire SHALL be (8 + max(payload, MIN_PAYLOAD) + 4) bytes x 4 cycles.

Reset
REQ-027 eth_rstn=0 SHALL asynchronously force state IDLE, eth_txen=0, eth_txd=00, tx_rdy=0, tx_err=0, and clear the counters and CRC state.
REQ-028 Reset mid-frame SHALL abandon the frame; the first frame after reset release SHALL start with a full preamble, with no IFG imposed.

Verification
REQ-029 60-byte payload 0x00..0x3B -> eth_txen high for exactly 288 cycles, preamble/SFD dibits as in REQ-016, FCS equal to the reference CRC-32, no tx_err.
REQ-030 14-byte payload -> 46 bytes of 0x00 padding, eth_txen high for 288 cycles, FCS computed over all 60 bytes.
REQ-031 tx_vld dropped at the 21st byte request -> tx_err pulse, 4 bytes of inverted FCS, eth_txen high for (8+20+4)*4 = 128 cycles.
REQ-032 Two frames with tx_vld held high -> second eth_txen rise exactly 48+1 cycles after the first eth_txen fall.
REQ-033 1515-byte stream -> inverted FCS after byte 1514, tx_err pulse, 1515th byte drained via tx_rdy, eth_txen low throughout DRAIN.
REQ-034 eth_rstn pulsed low during DATA -> eth_txen=0 immediately (asynchronously); next tx_vld -> clean 32-cycle preamble and a valid frame.
